// File: rtl/csr_bus_arbiter.sv
// csr_bus_arbiter
//   Shares the single CSR port of cdbus between the host CSR master
//   (qspi_slave, never stalled) and an auxiliary on-chip agent that uses a
//   wait-request handshake. Host has fixed priority. One registered CSR
//   transaction is issued per cycle, and read data is routed back to its
//   owner through an in-flight tag pipeline READ_LAT entries deep.
//
// Ports
//   clk, rst                   : clock, synchronous active-high reset
//   h_address/h_read/h_write/
//   h_writedata                : host command, single-cycle strobes
//   h_readdata/h_readvalid     : host read return
//   a_address/a_read/a_write/
//   a_writedata                : aux command, held until accepted
//   a_waitrequest              : aux command not accepted this cycle
//   a_readdata/a_readvalid     : aux read return
//   a_starve                   : aux blocked STARVE_MAX+ consecutive cycles
//   chip_select/csr_address/csr_read/csr_write/csr_writedata
//                              : registered issue port to cdbus
//   csr_readdata               : read data from cdbus
module csr_bus_arbiter #(
  parameter int A_WIDTH    = 5,
  parameter int D_WIDTH    = 8,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 64
) (
  input  logic               clk,
  input  logic               rst,

  input  logic [A_WIDTH-1:0] h_address,
  input  logic               h_read,
  input  logic               h_write,
  input  logic [D_WIDTH-1:0] h_writedata,
  output logic [D_WIDTH-1:0] h_readdata,
  output logic               h_readvalid,

  input  logic [A_WIDTH-1:0] a_address,
  input  logic               a_read,
  input  logic               a_write,
  input  logic [D_WIDTH-1:0] a_writedata,
  output logic               a_waitrequest,
  output logic [D_WIDTH-1:0] a_readdata,
  output logic               a_readvalid,
  output logic               a_starve,

  output logic               chip_select,
  output logic [A_WIDTH-1:0] csr_address,
  output logic               csr_read,
  output logic               csr_write,
  output logic [D_WIDTH-1:0] csr_writedata,
  input  logic [D_WIDTH-1:0] csr_readdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_MAX_C = CW'(STARVE_MAX);

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_AUX  = 1'b1
  } owner_t;

  logic               h_req;
  logic               a_req;
  logic               a_accept;

  logic               issue_rd;
  logic               issue_wr;
  logic [A_WIDTH-1:0] issue_addr;
  logic [D_WIDTH-1:0] issue_wd;
  owner_t             issue_owner;

  owner_t             csr_owner;

  logic [READ_LAT-1:0] tag_v;
  owner_t              tag_o [READ_LAT];
  logic                head_v;
  owner_t              head_o;

  logic [CW-1:0]      starve_cnt;

  // Grant decision. A port with both strobes set is treated as a write,
  // so the read strobe is masked by the write strobe.
  always_comb begin
    h_req         = h_read | h_write;
    a_req         = a_read | a_write;
    a_waitrequest = a_req & (h_req | rst);
    a_accept      = a_req & ~a_waitrequest;

    issue_rd    = 1'b0;
    issue_wr    = 1'b0;
    issue_addr  = csr_address;
    issue_wd    = csr_writedata;
    issue_owner = OWN_HOST;

    if (h_req) begin
      issue_wr    = h_write;
      issue_rd    = h_read & ~h_write;
      issue_addr  = h_address;
      issue_wd    = h_writedata;
      issue_owner = OWN_HOST;
    end else if (a_accept) begin
      issue_wr    = a_write;
      issue_rd    = a_read & ~a_write;
      issue_addr  = a_address;
      issue_wd    = a_writedata;
      issue_owner = OWN_AUX;
    end
  end

  // Issue register. Address/data hold across idle cycles; only the
  // strobes return to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_read      <= 1'b0;
      csr_write     <= 1'b0;
      csr_address   <= '0;
      csr_writedata <= '0;
      csr_owner     <= OWN_HOST;
    end else begin
      csr_read      <= issue_rd;
      csr_write     <= issue_wr;
      csr_address   <= issue_addr;
      csr_writedata <= issue_wd;
      csr_owner     <= issue_owner;
    end
  end

  assign chip_select = csr_read | csr_write;

  // Tag pipeline: stage 0 is loaded in the cycle after csr_read is on the
  // bus, so the head lines up with the cycle csr_readdata is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= csr_read;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_o[0] <= csr_owner;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      tag_o[i] <= tag_o[i-1];
    end
  end

  assign head_v = tag_v[READ_LAT-1];
  assign head_o = tag_o[READ_LAT-1];

  // Read return: only the owner's data register is updated.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_readdata  <= '0;
      h_readvalid <= 1'b0;
      a_readdata  <= '0;
      a_readvalid <= 1'b0;
    end else begin
      h_readvalid <= head_v & (head_o == OWN_HOST);
      a_readvalid <= head_v & (head_o == OWN_AUX);
      if (head_v && head_o == OWN_HOST) begin
        h_readdata <= csr_readdata;
      end
      if (head_v && head_o == OWN_AUX) begin
        a_readdata <= csr_readdata;
      end
    end
  end

  // Starvation counter: counts consecutive blocked requesting cycles and
  // saturates; any accepted or idle aux cycle clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (a_req & a_waitrequest) begin
      if (starve_cnt != STARVE_MAX_C) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  assign a_starve = (starve_cnt == STARVE_MAX_C);

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Testbench for csr_bus_arbiter: directed scenarios followed by random
// traffic, checked cycle by cycle against a schedule-based reference model.
module tb_csr_bus_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 8;
  localparam int RL   = 2;
  localparam int SM   = 4;
  localparam int NCYC = 1500;
  localparam int ASZ  = NCYC + 16;

  logic          clk;
  logic          rst;
  logic [AW-1:0] h_address;
  logic          h_read;
  logic          h_write;
  logic [DW-1:0] h_writedata;
  logic [DW-1:0] h_readdata;
  logic          h_readvalid;
  logic [AW-1:0] a_address;
  logic          a_read;
  logic          a_write;
  logic [DW-1:0] a_writedata;
  logic          a_waitrequest;
  logic [DW-1:0] a_readdata;
  logic          a_readvalid;
  logic          a_starve;
  logic          chip_select;
  logic [AW-1:0] csr_address;
  logic          csr_read;
  logic          csr_write;
  logic [DW-1:0] csr_writedata;
  logic [DW-1:0] csr_readdata;

  csr_bus_arbiter #(
    .A_WIDTH   (AW),
    .D_WIDTH   (DW),
    .READ_LAT  (RL),
    .STARVE_MAX(SM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .h_address    (h_address),
    .h_read       (h_read),
    .h_write      (h_write),
    .h_writedata  (h_writedata),
    .h_readdata   (h_readdata),
    .h_readvalid  (h_readvalid),
    .a_address    (a_address),
    .a_read       (a_read),
    .a_write      (a_write),
    .a_writedata  (a_writedata),
    .a_waitrequest(a_waitrequest),
    .a_readdata   (a_readdata),
    .a_readvalid  (a_readvalid),
    .a_starve     (a_starve),
    .chip_select  (chip_select),
    .csr_address  (csr_address),
    .csr_read     (csr_read),
    .csr_write    (csr_write),
    .csr_writedata(csr_writedata),
    .csr_readdata (csr_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle %0d %s: got %0h expected %0h", cur_cyc, tag, got, exp);
    end
  endtask

  // Expected-event schedule, indexed by cycle number.
  bit            e_rd     [ASZ];
  bit            e_wr     [ASZ];
  logic [AW-1:0] e_addr   [ASZ];
  logic [DW-1:0] e_wd     [ASZ];
  bit            e_hv     [ASZ];
  bit            e_av     [ASZ];
  int            e_src    [ASZ];
  bit            e_rst    [ASZ];
  bit            e_starve [ASZ];
  logic [DW-1:0] rd_drv   [ASZ];

  // Aux master state
  bit            ap;
  bit            ap_rd;
  bit            ap_wr;
  logic [AW-1:0] ap_addr;
  logic [DW-1:0] ap_wd;

  bit            hreq;
  bit            areq;
  bit            exp_wait;
  bit            accepted;
  int            blocked;
  int            p;
  int            kind;
  logic [DW-1:0] hh;
  logic [DW-1:0] ah;

  initial begin
    ap = 0; ap_rd = 0; ap_wr = 0; ap_addr = '0; ap_wd = '0;
    blocked = 0; hh = '0; ah = '0;
    rst = 1'b1; h_read = 0; h_write = 0; h_address = '0; h_writedata = '0;
    a_read = 0; a_write = 0; a_address = '0; a_writedata = '0; csr_readdata = '0;

    for (int c = 0; c <= NCYC; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      cur_cyc = c;

      // ---- host stimulus ----
      rst = (c < 3) || (c == 61) || (c >= 70 && $urandom_range(0, 99) == 0);
      h_read = 0;
      h_write = 0;
      h_address = AW'($urandom);
      h_writedata = DW'($urandom);
      if (c == 10) begin
        h_write = 1; h_address = 5'h03; h_writedata = 8'hA5;
      end else if (c == 14) begin
        h_read = 1; h_address = 5'h01;
      end else if (c == 20) begin
        h_read = 1; h_address = 5'h05;
      end else if (c == 30) begin
        h_read = 1; h_address = 5'h02;
      end else if (c >= 40 && c < 50) begin
        h_read = 1; h_write = 1'($urandom);
      end else if (c == 60) begin
        h_read = 1; h_address = 5'h04;
      end else if (c >= 70) begin
        p = ((c / 100) % 2 == 1) ? 80 : 40;
        if ($urandom_range(0, 99) < p) begin
          kind = $urandom_range(0, 2);
          h_read  = (kind != 1);
          h_write = (kind != 0);
        end
      end

      // ---- aux stimulus (held until accepted) ----
      if (c == 20) begin
        ap = 1; ap_rd = 0; ap_wr = 1; ap_addr = 5'h07; ap_wd = 8'h11;
      end else if (c == 31) begin
        ap = 1; ap_rd = 1; ap_wr = 0; ap_addr = 5'h06; ap_wd = 8'h00;
      end else if (c == 40) begin
        ap = 1; ap_rd = 0; ap_wr = 1; ap_addr = 5'h0A; ap_wd = 8'h3C;
      end else if (c >= 70 && !ap && $urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 2);
        ap = 1; ap_rd = (kind != 1); ap_wr = (kind != 0);
        ap_addr = AW'($urandom); ap_wd = DW'($urandom);
      end
      a_read = ap & ap_rd;
      a_write = ap & ap_wr;
      a_address = ap_addr;
      a_writedata = ap_wd;

      csr_readdata = (c == 17) ? 8'h5C : DW'($urandom);
      rd_drv[c] = csr_readdata;

      // ---- reference model ----
      hreq = h_read | h_write;
      areq = a_read | a_write;
      exp_wait = areq & (hreq | rst);
      accepted = areq & !exp_wait;
      if (rst) begin
        for (int k = c + 1; k <= c + RL + 3; k++) begin
          e_rd[k] = 0; e_wr[k] = 0; e_hv[k] = 0; e_av[k] = 0; e_rst[k] = 0;
        end
        e_rst[c+1] = 1;
        blocked = 0;
      end else begin
        if (hreq) begin
          e_wr[c+1] = h_write;
          e_rd[c+1] = h_read & !h_write;
          e_addr[c+1] = h_address;
          e_wd[c+1] = h_writedata;
          if (h_read && !h_write) begin
            e_hv[c+2+RL] = 1;
            e_src[c+2+RL] = c + 1 + RL;
          end
        end else if (areq) begin
          e_wr[c+1] = a_write;
          e_rd[c+1] = a_read & !a_write;
          e_addr[c+1] = a_address;
          e_wd[c+1] = a_writedata;
          if (a_read && !a_write) begin
            e_av[c+2+RL] = 1;
            e_src[c+2+RL] = c + 1 + RL;
          end
        end
        blocked = (areq && hreq) ? ((blocked + 1 > SM) ? SM : blocked + 1) : 0;
      end
      e_starve[c+1] = (blocked == SM);

      if (e_rst[c]) begin
        hh = '0;
        ah = '0;
      end
      if (e_hv[c]) hh = rd_drv[e_src[c]];
      if (e_av[c]) ah = rd_drv[e_src[c]];

      // ---- compare ----
      if (c > 0) begin
        @(negedge clk);
        check("a_waitrequest", 32'(a_waitrequest), 32'(exp_wait));
        check("csr_read", 32'(csr_read), 32'(e_rd[c]));
        check("csr_write", 32'(csr_write), 32'(e_wr[c]));
        check("chip_select", 32'(chip_select), 32'(e_rd[c] | e_wr[c]));
        if (e_rd[c] || e_wr[c]) begin
          check("csr_address", 32'(csr_address), 32'(e_addr[c]));
        end
        if (e_wr[c]) begin
          check("csr_writedata", 32'(csr_writedata), 32'(e_wd[c]));
        end
        if (e_rst[c]) begin
          check("rst_csr_address", 32'(csr_address), 32'h0);
          check("rst_csr_writedata", 32'(csr_writedata), 32'h0);
        end
        check("h_readvalid", 32'(h_readvalid), 32'(e_hv[c]));
        check("a_readvalid", 32'(a_readvalid), 32'(e_av[c]));
        check("h_readdata", 32'(h_readdata), 32'(hh));
        check("a_readdata", 32'(a_readdata), 32'(ah));
        check("a_starve", 32'(a_starve), 32'(e_starve[c]));
      end

      if (accepted) ap = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_bus_arbiter.md
# csr_bus_arbiter

Shares the single 8-bit CSR port of `cdbus` between two requesters. The host side is the `qspi_slave` CSR master, which can never be stalled. The auxiliary side is an on-chip agent, such as an IRQ service or auto-configuration engine, that uses a wait-request handshake. The block sits between those masters and `cdbus`, issues one registered CSR transaction per cycle, drives `chip_select`, and routes read data back to the owner using an in-flight tag pipeline.

## Interface
Parameters:
- `A_WIDTH`, 5: CSR address width.
- `D_WIDTH`, 8: CSR data width.
- `READ_LAT`, 1: cycles from a `csr_read` cycle until `csr_readdata` is valid. Legal values are 1 to 4.
- `STARVE_MAX`, 64: blocked-cycle count at which the aux starvation flag asserts.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `h_address` in A_WIDTH; `h_read` in 1; `h_write` in 1; `h_writedata` in D_WIDTH: host command, single-cycle strobes.
- `h_readdata` out D_WIDTH; `h_readvalid` out 1: host read return.
- `a_address` in A_WIDTH; `a_read` in 1; `a_write` in 1; `a_writedata` in D_WIDTH: aux command, held until accepted.
- `a_waitrequest` out 1: aux command is not accepted this cycle.
- `a_readdata` out D_WIDTH; `a_readvalid` out 1: aux read return.
- `a_starve` out 1: aux has been blocked for `STARVE_MAX` or more consecutive requesting cycles.
- `chip_select` out 1; `csr_address` out A_WIDTH; `csr_read` out 1; `csr_write` out 1; `csr_writedata` out D_WIDTH: registered issue port to `cdbus`.
- `csr_readdata` in D_WIDTH: read data from `cdbus`.

## Operation
- Request definitions:
  - `h_req = h_read | h_write`
  - `a_req = a_read | a_write`
  - If read and write are both asserted on one port, the request is treated as a write.
- Fixed priority, host first. The host is never stalled.
- Grant decision, made every cycle:
  - If `h_req` is high, the host wins.
  - Otherwise, if `a_req` is high, aux wins.
  - Otherwise the cycle is idle.
- `a_waitrequest = a_req & (h_req | rst)`. This is combinational. It is low whenever aux is not requesting.
- Aux acceptance happens in a cycle with `a_req=1` and `a_waitrequest=0`. The aux master must hold address, data and strobes stable until that cycle.
- Issue register: the winner's address, data and strobe are registered into `csr_*`. `chip_select` equals `csr_read | csr_write`. All strobes are high for exactly one cycle per accepted command.
- Tag pipeline: a shift register `READ_LAT` deep, each entry holding {valid, owner}. An entry is pushed for every issued `csr_read`.
  - When the entry reaches the head, `csr_readdata` is captured into `h_readdata` or `a_readdata` according to the owner, and the matching `*_readvalid` pulses for one cycle.
  - The non-owner's data register holds its previous value.
- Starve counter, `$clog2(STARVE_MAX+1)` bits:
  - Increments on each cycle with `a_req & a_waitrequest`.
  - Saturates at `STARVE_MAX`.
  - Clears on aux acceptance or when `a_req` is low.
  - `a_starve = (count == STARVE_MAX)`.
- Reset, while `rst` is high:
  - All `csr_*` outputs, `chip_select`, both `*_readvalid`, both `*_readdata` (0x00), `a_starve` and the counter are cleared.
  - Tag pipeline valids are cleared, so a read in flight produces no return.
  - Host strobes are ignored and aux is held off.

## Timing
- A command accepted in cycle N has `csr_*` asserted in cycle N+1.
- For a read accepted in cycle N:
  - `csr_readdata` is sampled at the end of cycle N+1+`READ_LAT`.
  - `*_readdata` and `*_readvalid` are visible in cycle N+2+`READ_LAT`.
- Throughput is one command per cycle. Back-to-back reads, including alternating owners, each return in order with the correct tag.
- Host read latency seen by `qspi_slave` is fixed at `READ_LAT`+2 cycles and does not depend on aux activity.
- Simultaneous host and aux request: the host issues and aux waits. Aux issues in the first cycle the host is idle.
- Reset asserted mid-read: no `readvalid` pulse ever occurs for that read, even after `rst` is released.

## Test plan
- Host write alone, `READ_LAT`=1:
  - Stimulus: `h_write`, address 0x03, data 0xA5 in cycle 10.
  - Required: `csr_write`=1, `chip_select`=1, address 0x03, data 0xA5 in cycle 11 only. No `readvalid` pulse.
- Host read alone, `READ_LAT`=1:
  - Stimulus: `h_read` of 0x01 in cycle 10; `cdbus` returns 0x5C in cycle 12.
  - Required: `h_readdata`=0x5C and `h_readvalid`=1 in cycle 13. `a_readvalid` stays 0.
- Collision:
  - Stimulus: `h_read` and `a_write` (0x07 ← 0x11) both in cycle 20.
  - Required: `a_waitrequest`=1 in cycle 20. Host read issues in cycle 21. Aux is accepted in cycle 21 if the host is idle, and `csr_write` of 0x07 occurs in cycle 22.
- Interleaved reads, `READ_LAT`=2:
  - Stimulus: host read in cycle 5, aux read accepted in cycle 6.
  - Required: host return in cycle 9 and aux return in cycle 10, each with its own data.
- Starvation, `STARVE_MAX`=4:
  - Stimulus: host strobes every cycle while aux requests.
  - Required: `a_starve`=1 on the 5th blocked cycle. It clears the cycle after the host goes idle and aux is accepted.
- Reset mid-read:
  - Stimulus: host read in cycle 10, `rst` asserted in cycle 11.
  - Required: all outputs 0 from cycle 12. No `h_readvalid` pulse follows.
